// File: rtl/bullet_controller_pkg.sv
// Shared types and constants for the tank game bullet engine.
// Map geometry, tile codes, facing directions and the bullet FSM states.
package tank_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    RIGHT = 2'd1,
    DOWN  = 2'd2,
    LEFT  = 2'd3
  } dir_t;

  localparam logic [2:0] TILE_EMPTY  = 3'd0;
  localparam logic [2:0] TILE_STEEL  = 3'd1;
  localparam logic [2:0] TILE_BRICK  = 3'd2;
  localparam logic [2:0] TILE_BASE_A = 3'd3;
  localparam logic [2:0] TILE_BASE_B = 3'd4;

  localparam int MAP_W = 20;
  localparam int MAP_H = 15;

  localparam logic [4:0] BUL_OFF_X = 5'd31;
  localparam logic [3:0] BUL_OFF_Y = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CHECK    = 3'd1,
    ST_FLY      = 3'd2,
    ST_CLEAR    = 3'd3,
    ST_END      = 3'd4,
    ST_COOLDOWN = 3'd5
  } bul_state_t;

  // Row-major tile index; callers only trust it for in-bounds tiles.
  function automatic logic [8:0] tile_idx(input logic [4:0] x, input logic [3:0] y);
    return ({5'd0, y} * 9'(MAP_W)) + {4'd0, x};
  endfunction

endpackage

// File: rtl/bullet_controller_if.sv
// Map-side handshakes of the bullet engine: tile read port and brick-clear request.
interface bullet_controller_if;

  logic [8:0] map_rd_idx;
  logic       map_rd_en;
  logic [2:0] map_rd_data;
  logic       brk_clr_valid;
  logic [8:0] brk_clr_idx;
  logic       brk_clr_ready;

  modport master (
    output map_rd_idx,
    output map_rd_en,
    input  map_rd_data,
    output brk_clr_valid,
    output brk_clr_idx,
    input  brk_clr_ready
  );

  modport slave (
    input  map_rd_idx,
    input  map_rd_en,
    output map_rd_data,
    input  brk_clr_valid,
    input  brk_clr_idx,
    output brk_clr_ready
  );

endinterface

// File: rtl/bullet_controller_tile_step.sv
// Combinational one-tile step in a facing direction, with map index and bounds flag.
module tile_step
  import tank_pkg::*;
(
  input  logic [4:0] x,
  input  logic [3:0] y,
  input  dir_t       dir,
  output logic [4:0] nx,
  output logic [3:0] ny,
  output logic [8:0] idx,
  output logic       oob
);

  logic outside;

  // A start tile already off the map can never yield a valid neighbour.
  assign outside = (x > 5'(MAP_W - 1)) || (y > 4'(MAP_H - 1));

  always_comb begin
    nx  = x;
    ny  = y;
    oob = outside;
    unique case (dir)
      UP: begin
        ny  = y - 4'd1;
        oob = outside || (y == 4'd0);
      end
      RIGHT: begin
        nx  = x + 5'd1;
        oob = outside || (x == 5'(MAP_W - 1));
      end
      DOWN: begin
        ny  = y + 4'd1;
        oob = outside || (y == 4'(MAP_H - 1));
      end
      LEFT: begin
        nx  = x - 5'd1;
        oob = outside || (x == 5'd0);
      end
    endcase
  end

  assign idx = tile_idx(nx, ny);

endmodule

// File: rtl/bullet_controller.sv
// Per-tank bullet engine feeding the colour mapper; steps one tile every STEP_FRAMES frames.
// Optional BULLET_COOLDOWN_EN adds a COOLDOWN_FRAMES fire lockout after each bullet ends.
module bullet_controller
  import tank_pkg::*;
#(
  parameter int STEP_FRAMES     = 4,
  parameter int COOLDOWN_FRAMES = 30
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic                       frame_tick,
  input  logic                       fire,
  input  logic [4:0]                 tank_x,
  input  logic [3:0]                 tank_y,
  input  dir_t                       tank_dir,
  input  logic [4:0]                 enemy_x,
  input  logic [3:0]                 enemy_y,
  bullet_controller_if.master        bus,
  output logic [4:0]                 bul_x,
  output logic [3:0]                 bul_y,
  output logic                       bul_active,
  output logic                       hit_enemy,
  output logic                       hit_base
);

  // One frame counter serves both the step pacing and the cooldown lockout.
  localparam int MAX_FRAMES = (STEP_FRAMES > COOLDOWN_FRAMES) ? STEP_FRAMES : COOLDOWN_FRAMES;
  localparam int CNT_W = $clog2(MAX_FRAMES + 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_FRAMES - 1);
`ifdef BULLET_COOLDOWN_EN
  localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOLDOWN_FRAMES - 1);
`endif

  bul_state_t       state;
  bul_state_t       state_nxt;
  logic             fire_q;
  logic             fire_edge;
  logic [CNT_W-1:0] cnt;
  dir_t             dir_q;
  logic [4:0]       cand_x;
  logic [3:0]       cand_y;
  logic [8:0]       cand_idx;
  logic             cand_enemy;
  logic             step_due;
  logic             rd_en;
  logic [8:0]       rd_idx;
  logic             brk_valid;
  logic [8:0]       brk_idx;

  logic [4:0]       step_x;
  logic [3:0]       step_y;
  dir_t             step_dir;
  logic [4:0]       nx;
  logic [3:0]       ny;
  logic [8:0]       nidx;
  logic             noob;

  assign fire_edge  = fire & ~fire_q;
  assign step_due   = (state == ST_FLY) && frame_tick && (cnt == STEP_LAST);
  assign cand_enemy = (cand_x == enemy_x) && (cand_y == enemy_y);

  // The single stepper looks from the tank while idle and from the bullet in flight.
  assign step_x   = (state == ST_FLY) ? bul_x : tank_x;
  assign step_y   = (state == ST_FLY) ? bul_y : tank_y;
  assign step_dir = (state == ST_FLY) ? dir_q : tank_dir;

  tile_step u_step (
    .x   (step_x),
    .y   (step_y),
    .dir (step_dir),
    .nx  (nx),
    .ny  (ny),
    .idx (nidx),
    .oob (noob)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (fire_edge && !noob) begin
          state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (cand_enemy) begin
          state_nxt = ST_END;
        end else if (bus.map_rd_data == TILE_EMPTY) begin
          state_nxt = ST_FLY;
        end else if (bus.map_rd_data == TILE_BRICK) begin
          state_nxt = ST_CLEAR;
        end else begin
          state_nxt = ST_END;
        end
      end
      ST_FLY: begin
        if (step_due) begin
          state_nxt = noob ? ST_END : ST_CHECK;
        end
      end
      ST_CLEAR: begin
        if (bus.brk_clr_ready) begin
          state_nxt = ST_END;
        end
      end
      ST_END: begin
`ifdef BULLET_COOLDOWN_EN
        state_nxt = ST_COOLDOWN;
`else
        state_nxt = ST_IDLE;
`endif
      end
      ST_COOLDOWN: begin
`ifdef BULLET_COOLDOWN_EN
        if (frame_tick && (cnt == COOL_LAST)) begin
          state_nxt = ST_IDLE;
        end
`else
        state_nxt = ST_IDLE;
`endif
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The read strobe is combinational so the synchronous map returns data during CHECK.
  always_comb begin
    rd_en  = 1'b0;
    rd_idx = 9'd0;
    if (((state == ST_IDLE) && fire_edge && !noob) || (step_due && !noob)) begin
      rd_en  = 1'b1;
      rd_idx = nidx;
    end
  end

  assign bus.map_rd_en     = rd_en;
  assign bus.map_rd_idx    = rd_idx;
  assign bus.brk_clr_valid = brk_valid;
  assign bus.brk_clr_idx   = brk_idx;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fire_q     <= 1'b0;
      cnt        <= '0;
      dir_q      <= UP;
      cand_x     <= 5'd0;
      cand_y     <= 4'd0;
      cand_idx   <= 9'd0;
      bul_x      <= BUL_OFF_X;
      bul_y      <= BUL_OFF_Y;
      bul_active <= 1'b0;
      brk_valid  <= 1'b0;
      brk_idx    <= 9'd0;
      hit_enemy  <= 1'b0;
      hit_base   <= 1'b0;
    end else begin
      fire_q    <= fire;
      hit_enemy <= 1'b0;
      hit_base  <= 1'b0;
      if (rd_en) begin
        cand_x   <= nx;
        cand_y   <= ny;
        cand_idx <= nidx;
      end
      if (rd_en && (state == ST_IDLE)) begin
        dir_q <= tank_dir;
      end
      unique case (state)
        ST_CHECK: begin
          if (cand_enemy) begin
            hit_enemy <= 1'b1;
          end else if (bus.map_rd_data == TILE_EMPTY) begin
            bul_x      <= cand_x;
            bul_y      <= cand_y;
            bul_active <= 1'b1;
            cnt        <= '0;
          end else if (bus.map_rd_data == TILE_BRICK) begin
            brk_valid <= 1'b1;
            brk_idx   <= cand_idx;
          end else if ((bus.map_rd_data == TILE_BASE_A) || (bus.map_rd_data == TILE_BASE_B)) begin
            hit_base <= 1'b1;
          end
        end
        ST_FLY: begin
          if (frame_tick) begin
            cnt <= (cnt == STEP_LAST) ? '0 : cnt + CNT_W'(1);
          end
        end
        ST_CLEAR: begin
          if (bus.brk_clr_ready) begin
            brk_valid <= 1'b0;
          end
        end
        ST_END: begin
          bul_active <= 1'b0;
          bul_x      <= BUL_OFF_X;
          bul_y      <= BUL_OFF_Y;
          cnt        <= '0;
        end
        ST_COOLDOWN: begin
`ifdef BULLET_COOLDOWN_EN
          if (frame_tick) begin
            cnt <= (cnt == COOL_LAST) ? '0 : cnt + CNT_W'(1);
          end
`endif
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bullet_controller.sv
// Directed bench for bullet_controller with a synchronous map model and hand-computed expectations.
// Honours BULLET_COOLDOWN_EN by waiting out (and probing) the cooldown window.
module tb_bullet_controller;
  import tank_pkg::*;

  localparam int STEP = 4;
  localparam int COOL = 30;

  logic       clk;
  logic       rst_n;
  logic       frame_tick;
  logic       fire;
  logic [4:0] tank_x;
  logic [3:0] tank_y;
  dir_t       tank_dir;
  logic [4:0] enemy_x;
  logic [3:0] enemy_y;
  logic [4:0] bul_x;
  logic [3:0] bul_y;
  logic       bul_active;
  logic       hit_enemy;
  logic       hit_base;

  logic [2:0] tileMap [0:299];
  int checkCount;
  int failCount;

  bullet_controller_if bif ();

  bullet_controller #(
    .STEP_FRAMES     (STEP),
    .COOLDOWN_FRAMES (COOL)
  ) dut (
    .Clk        (clk),
    .Reset_n    (rst_n),
    .frame_tick (frame_tick),
    .fire       (fire),
    .tank_x     (tank_x),
    .tank_y     (tank_y),
    .tank_dir   (tank_dir),
    .enemy_x    (enemy_x),
    .enemy_y    (enemy_y),
    .bus        (bif),
    .bul_x      (bul_x),
    .bul_y      (bul_y),
    .bul_active (bul_active),
    .hit_enemy  (hit_enemy),
    .hit_base   (hit_base)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous map RAM: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (bif.map_rd_en) begin
      bif.map_rd_data <= tileMap[bif.map_rd_idx];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] tx, input logic [3:0] ty, input dir_t td);
    tank_x   = tx;
    tank_y   = ty;
    tank_dir = td;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Each tick is a one-cycle pulse followed by one quiet cycle.
  task automatic sendTicks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      cycles(1);
      frame_tick = 1'b0;
      cycles(1);
    end
  endtask

  task automatic waitCooldown();
`ifdef BULLET_COOLDOWN_EN
    sendTicks(COOL);
`endif
  endtask

  task automatic clearMap();
    for (int i = 0; i < 300; i++) begin
      tileMap[i] = TILE_EMPTY;
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_active"}, 32'(bul_active), 32'd0);
    checkOutput({tag, "_x"}, 32'(bul_x), 32'd31);
    checkOutput({tag, "_y"}, 32'(bul_y), 32'd15);
  endtask

  // Fire from the current tank pose and check the bullet appears two cycles later.
  task automatic fireAndExpect(input string tag, input logic [31:0] idx, input logic [31:0] ex, input logic [31:0] ey);
    fire = 1'b1;
    #1;
    checkOutput({tag, "_rden"}, 32'(bif.map_rd_en), 32'd1);
    checkOutput({tag, "_rdidx"}, 32'(bif.map_rd_idx), idx);
    cycles(1);
    checkOutput({tag, "_notyet"}, 32'(bul_active), 32'd0);
    cycles(1);
    checkOutput({tag, "_active"}, 32'(bul_active), 32'd1);
    checkOutput({tag, "_x"}, 32'(bul_x), ex);
    checkOutput({tag, "_y"}, 32'(bul_y), ey);
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    rst_n      = 1'b0;
    frame_tick = 1'b0;
    fire       = 1'b0;
    enemy_x    = 5'd19;
    enemy_y    = 4'd14;
    bif.brk_clr_ready = 1'b0;
    applyStimulus(5'd5, 4'd5, UP);
    clearMap();

    cycles(2);
    checkIdleOutputs("reset");
    checkOutput("reset_rden", 32'(bif.map_rd_en), 32'd0);
    checkOutput("reset_rdidx", 32'(bif.map_rd_idx), 32'd0);
    checkOutput("reset_brkv", 32'(bif.brk_clr_valid), 32'd0);
    checkOutput("reset_brkidx", 32'(bif.brk_clr_idx), 32'd0);
    checkOutput("reset_hite", 32'(hit_enemy), 32'd0);
    checkOutput("reset_hitb", 32'(hit_base), 32'd0);
    rst_n = 1'b1;
    cycles(2);

    // Straight flight upward from (5,5) until it leaves the top edge.
    fireAndExpect("up", 32'd85, 32'd5, 32'd4);
    fire = 1'b0;
    sendTicks(3);
    checkOutput("up_hold3", 32'(bul_y), 32'd4);
    frame_tick = 1'b1;
    cycles(1);
    frame_tick = 1'b0;
    checkOutput("up_tick4_same", 32'(bul_y), 32'd4);
    cycles(1);
    checkOutput("up_step_y", 32'(bul_y), 32'd3);
    checkOutput("up_step_x", 32'(bul_x), 32'd5);
    for (int y = 2; y >= 0; y--) begin
      sendTicks(STEP);
      checkOutput("up_walk_y", 32'(bul_y), 32'(y));
    end
    sendTicks(STEP);
    checkIdleOutputs("up_oob");
`ifdef BULLET_COOLDOWN_EN
    sendTicks(10);
    fire = 1'b1;
    #1;
    checkOutput("cool_rden", 32'(bif.map_rd_en), 32'd0);
    cycles(2);
    checkOutput("cool_active", 32'(bul_active), 32'd0);
    fire = 1'b0;
    sendTicks(COOL - 10);
`endif

    // Brick at (5,7) on a rightward shot, ready withheld for three cycles.
    clearMap();
    tileMap[145] = TILE_BRICK;
    applyStimulus(5'd3, 4'd7, RIGHT);
    fireAndExpect("brk", 32'd144, 32'd4, 32'd7);
    fire = 1'b0;
    sendTicks(STEP);
    checkOutput("brk_valid", 32'(bif.brk_clr_valid), 32'd1);
    checkOutput("brk_idx", 32'(bif.brk_clr_idx), 32'd145);
    checkOutput("brk_bulx", 32'(bul_x), 32'd4);
    for (int i = 0; i < 3; i++) begin
      cycles(1);
      checkOutput("brk_hold_valid", 32'(bif.brk_clr_valid), 32'd1);
      checkOutput("brk_hold_idx", 32'(bif.brk_clr_idx), 32'd145);
    end
    bif.brk_clr_ready = 1'b1;
    cycles(1);
    bif.brk_clr_ready = 1'b0;
    checkOutput("brk_drop", 32'(bif.brk_clr_valid), 32'd0);
    checkOutput("brk_end_active", 32'(bul_active), 32'd1);
    cycles(1);
    checkIdleOutputs("brk_done");
    waitCooldown();

    // Corner shot off the map: nothing happens.
    applyStimulus(5'd0, 4'd0, LEFT);
    fire = 1'b1;
    #1;
    checkOutput("oob_rden", 32'(bif.map_rd_en), 32'd0);
    cycles(2);
    checkOutput("oob_active", 32'(bul_active), 32'd0);
    checkOutput("oob_rden2", 32'(bif.map_rd_en), 32'd0);
    fire = 1'b0;
    cycles(1);

    // Enemy at (10,2): struck without the bullet ever being shown there.
    clearMap();
    enemy_x = 5'd10;
    enemy_y = 4'd2;
    applyStimulus(5'd10, 4'd5, UP);
    fireAndExpect("enemy", 32'd90, 32'd10, 32'd4);
    fire = 1'b0;
    sendTicks(STEP);
    checkOutput("enemy_y3", 32'(bul_y), 32'd3);
    sendTicks(STEP - 1);
    frame_tick = 1'b1;
    cycles(1);
    frame_tick = 1'b0;
    checkOutput("enemy_check_hit", 32'(hit_enemy), 32'd0);
    cycles(1);
    checkOutput("enemy_hit", 32'(hit_enemy), 32'd1);
    checkOutput("enemy_y_kept", 32'(bul_y), 32'd3);
    cycles(1);
    checkOutput("enemy_pulse_end", 32'(hit_enemy), 32'd0);
    checkIdleOutputs("enemy_done");
    enemy_x = 5'd19;
    enemy_y = 4'd14;
    waitCooldown();

    // Base tile directly below the tank.
    tileMap[228] = TILE_BASE_A;
    applyStimulus(5'd8, 4'd10, DOWN);
    fire = 1'b1;
    cycles(1);
    fire = 1'b0;
    cycles(1);
    checkOutput("base_hit", 32'(hit_base), 32'd1);
    checkOutput("base_active", 32'(bul_active), 32'd0);
    cycles(1);
    checkOutput("base_pulse_end", 32'(hit_base), 32'd0);
    waitCooldown();

    // Fire edges in flight are ignored; a held key across END does not refire.
    clearMap();
    applyStimulus(5'd5, 4'd5, UP);
    fireAndExpect("refire", 32'd85, 32'd5, 32'd4);
    fire = 1'b0;
    cycles(1);
    fire = 1'b1;
    #1;
    checkOutput("fly_edge_rden", 32'(bif.map_rd_en), 32'd0);
    cycles(1);
    checkOutput("fly_edge_y", 32'(bul_y), 32'd4);
    sendTicks(4 * STEP);
    checkOutput("held_y0", 32'(bul_y), 32'd0);
    sendTicks(STEP);
    checkIdleOutputs("held_end");
    waitCooldown();
    cycles(2);
    checkOutput("held_rden", 32'(bif.map_rd_en), 32'd0);
    checkOutput("held_active", 32'(bul_active), 32'd0);
    fire = 1'b0;
    cycles(1);
    fireAndExpect("fresh", 32'd85, 32'd5, 32'd4);
    fire = 1'b0;

    // Reset in flight, then reset while a brick clear is pending.
    rst_n = 1'b0;
    #1;
    checkIdleOutputs("rst_fly");
    cycles(1);
    rst_n = 1'b1;
    cycles(1);
    tileMap[145] = TILE_BRICK;
    applyStimulus(5'd3, 4'd7, RIGHT);
    fireAndExpect("rbrk", 32'd144, 32'd4, 32'd7);
    fire = 1'b0;
    sendTicks(STEP);
    checkOutput("rbrk_valid", 32'(bif.brk_clr_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_clr_valid", 32'(bif.brk_clr_valid), 32'd0);
    checkOutput("rst_clr_idx", 32'(bif.brk_clr_idx), 32'd0);
    checkIdleOutputs("rst_clr");
    cycles(1);
    rst_n = 1'b1;
    cycles(1);
    checkOutput("rst_after_valid", 32'(bif.brk_clr_valid), 32'd0);
    fireAndExpect("post_rst", 32'd144, 32'd4, 32'd7);
    fire = 1'b0;
    cycles(1);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/bullet_controller.md
Name: bullet_controller

Overview:
- Per-tank bullet engine that sits directly upstream of the colour mapper.
- Drives the bullet tile coordinates and the active flag that the mapper compares against DrawX[9:5]/DrawY[9:5].
- Advances the bullet one 32x32 tile every STEP_FRAMES frames and resolves collisions against the 20x15 tile map and the enemy tank.
- Issues brick-clear requests to the map owner.

Parameters:
STEP_FRAMES, 4, frame ticks between tile steps (>=1)
COOLDOWN_FRAMES, 30, frames fire is blocked after a bullet ends (used only with the optional feature)

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
frame_tick  in  1  single-Clk-cycle pulse once per frame (vsync rise, already in Clk domain)
fire  in  1  level fire key; rising edge detected internally
tank_x  in  5  own tank tile X (0..19)
tank_y  in  4  own tank tile Y (0..14)
tank_dir  in  2  own tank facing (dir_t)
enemy_x  in  5  enemy tank tile X
enemy_y  in  4  enemy tank tile Y
map_rd_idx  out  9  tile index y*20+x
map_rd_en  out  1  read strobe
map_rd_data  in  3  tile code, valid exactly 1 cycle after map_rd_en
brk_clr_valid  out  1  request to set tile to EMPTY
brk_clr_idx  out  9  tile to clear
brk_clr_ready  in  1  map owner accepts request
bul_x  out  5  bullet tile X; 31 when inactive
bul_y  out  4  bullet tile Y; 15 when inactive
bul_active  out  1  bullet in flight
hit_enemy  out  1  1-cycle pulse, enemy tank struck
hit_base  out  1  1-cycle pulse, base tile (code 3 or 4) struck

Behaviour:
- Reset (async, Reset_n=0) values: state IDLE, bul_x=31, bul_y=15, bul_active=0, map_rd_en=0, map_rd_idx=0, brk_clr_valid=0, brk_clr_idx=0, hit_enemy=0, hit_base=0, frame counter 0, fire edge register 0. Reset mid-flight or mid-CLEAR abandons everything; no request stays pending.
- Tile codes: 0 EMPTY, 1 STEEL, 2 BRICK, 3/4 BASE, 5-7 treated as STEEL.
- Next tile: UP y-1, RIGHT x+1, DOWN y+1, LEFT x-1. Out of bounds means x<0, x>19, y<0 or y>14.
- Index arithmetic: idx = y*20 + x, 9 bits unsigned, max 299.
- IDLE:
  - fire rising edge computes the next tile from tank_x/tank_y/tank_dir and latches the direction.
  - If the next tile is out of bounds, stay IDLE with no output change.
  - Otherwise pulse map_rd_en for that idx and go to CHECK.
  - fire edges are ignored in every other state.
- CHECK (1 cycle, map_rd_data valid), in priority order:
  - Candidate tile == (enemy_x, enemy_y): hit_enemy pulse, go to END.
  - EMPTY: load bul_x/bul_y with the candidate, bul_active=1, clear counter, go to FLY.
  - BRICK: brk_clr_idx=candidate, brk_clr_valid=1, go to CLEAR.
  - BASE: hit_base pulse, go to END.
  - STEEL: go to END.
- FLY:
  - Each frame_tick increments the counter.
  - On the tick where counter == STEP_FRAMES-1: clear counter and compute the next tile from bul_x/bul_y plus the latched direction.
  - Out of bounds goes to END. Otherwise pulse map_rd_en and go to CHECK.
  - bul_x/bul_y stay unchanged until CHECK accepts the new tile.
- CLEAR: hold brk_clr_valid and brk_clr_idx stable until the cycle brk_clr_ready=1. Drop valid the next cycle and go to END.
- END (1 cycle): bul_active=0, bul_x=31, bul_y=15, go to IDLE.
- Latency:
  - Fire edge to bul_active=1 is 2 cycles.
  - Step frame_tick to new coordinates is 2 cycles.
  - frame_tick arriving during CHECK/CLEAR/END is not counted.

Optional Feature:
- Macro BULLET_COOLDOWN_EN.
- Defined: END goes to COOLDOWN, which counts COOLDOWN_FRAMES frame_ticks and then goes to IDLE. Fire edges during COOLDOWN are dropped, not queued.
- Undefined: END goes straight to IDLE and COOLDOWN_FRAMES is unused.

Decomposition:
- Package tank_pkg:
  - dir_t enum (UP=0, RIGHT=1, DOWN=2, LEFT=3)
  - tile codes TILE_EMPTY, TILE_STEEL, TILE_BRICK, TILE_BASE_A, TILE_BASE_B
  - MAP_W=20, MAP_H=15
  - BUL_OFF_X=31, BUL_OFF_Y=15
  - bullet state enum
- One combinational sub-module, tile_step:
  - Inputs: x, y, dir.
  - Outputs: nx, ny, idx, oob.
  - Instantiated once, with inputs muxed between the tank position (IDLE) and the bullet position (FLY).

Test Plan:
- Tank (5,5) UP, tiles (5,4)..(5,0) EMPTY, fire edge -> bul_active=1 at (5,4) 2 cycles later; with STEP_FRAMES=4, moves to (5,3) after the 4th frame_tick, reaches (5,0), next step out of bounds -> END, bul_x=31, bul_active=0.
- Tank (3,7) RIGHT, tile (4,7) EMPTY, (5,7) BRICK, ready held 0 for 3 cycles -> brk_clr_idx=145 stays stable, valid held; clears on ready, bullet deactivates.
- Tank (0,0) LEFT, fire -> no map_rd_en, bul_active stays 0.
- Enemy at (10,2), tank (10,5) UP, path empty -> hit_enemy single pulse when the candidate is (10,2); bullet never displayed at (10,2).
- Fire edges while active, and fire held high across END -> no second bullet until a fresh 0->1 edge; with BULLET_COOLDOWN_EN and COOLDOWN_FRAMES=30, an edge at frame 10 of cooldown is ignored.
- Reset_n asserted during CLEAR -> brk_clr_valid=0 immediately (asynchronous), all outputs at reset values; after release, fire works normally.
